// File: rtl/riscv_pipe_pkg.sv
// Shared types and default widths for the RISC-V pipeline registers.
package riscv_pipe_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int PC_W_DEF  = 32;
    localparam int REG_W_DEF = 5;

    // Control bits travelling with an EX/MEM entry.
    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
        logic branch;
        logic mem_read;
        logic mem_write;
    } ex_mem_ctrl_t;

    localparam int CTRL_W = $bits(ex_mem_ctrl_t);

    // Full EX/MEM entry at the default widths.
    typedef struct packed {
        logic [XLEN_DEF-1:0]  alu_data;
        logic [XLEN_DEF-1:0]  rs2_data;
        logic [PC_W_DEF-1:0]  pc_branch;
        logic                 zero;
        logic [REG_W_DEF-1:0] rd;
        ex_mem_ctrl_t         ctrl;
    } ex_mem_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
//
// Handshake: an entry moves across an interface on a rising edge where
// valid & ready are both 1. in_ready comes straight from a flop
// (~skid_valid), so there is no combinational path from out_ready to
// in_ready. Once out_valid is raised, out_data holds stable until the
// entry is consumed (out_ready = 1) or flushed.
module pipe_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid;
    logic [WIDTH-1:0] main_data;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             accept;
    logic             main_free;

    assign in_ready  = ~skid_valid;
    assign accept    = in_valid & ~skid_valid;
    // Main can take a new entry this edge if it is empty or being drained.
    assign main_free = ~main_valid | out_ready;

    assign out_valid = main_valid;
    assign out_data  = main_data;

    // Main/skid update: skid drains first to keep FIFO order; flush wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_data  <= skid_data;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_data  <= in_data;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with skid buffering, flush, valid-gated
// forwarding/branch outputs and a saturating stall counter.
module ex_mem_skid_reg
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int PC_W  = PC_W_DEF,
    parameter int REG_W = REG_W_DEF,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  alu_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [PC_W-1:0]  pc_branch,
    input  logic             zero,
    input  logic [REG_W-1:0] rd,
    input  logic             mem_to_reg,
    input  logic             reg_write,
    input  logic             branch,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  alu_data_out,
    output logic [XLEN-1:0]  rs2_data_out,
    output logic [PC_W-1:0]  pc_branch_out,
    output logic             zero_out,
    output logic [REG_W-1:0] rd_out,
    output logic             mem_to_reg_out,
    output logic             reg_write_out,
    output logic             branch_out,
    output logic             mem_read_out,
    output logic             mem_write_out,
    output logic             pcsrc,
    output logic             fwd_valid,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int PAY_W = 2*XLEN + PC_W + 1 + REG_W + CTRL_W;

    ex_mem_ctrl_t     in_ctrl;
    ex_mem_ctrl_t     q_ctrl;
    logic [PAY_W-1:0] in_pay;
    logic [PAY_W-1:0] q_pay;
    logic             q_valid;

    assign in_ctrl.mem_to_reg = mem_to_reg;
    assign in_ctrl.reg_write  = reg_write;
    assign in_ctrl.branch     = branch;
    assign in_ctrl.mem_read   = mem_read;
    assign in_ctrl.mem_write  = mem_write;

    assign in_pay = {alu_data, rs2_data, pc_branch, zero, rd, in_ctrl};

    pipe_skid_buf #(
        .WIDTH (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pay),
        .out_valid (q_valid),
        .out_ready (out_ready),
        .out_data  (q_pay)
    );

    assign {alu_data_out, rs2_data_out, pc_branch_out, zero_out, rd_out, q_ctrl} = q_pay;

    assign out_valid = q_valid;

    // Controls are gated so a stale payload after flush has no effect in MEM.
    assign mem_to_reg_out = q_ctrl.mem_to_reg & q_valid;
    assign reg_write_out  = q_ctrl.reg_write  & q_valid;
    assign branch_out     = q_ctrl.branch     & q_valid;
    assign mem_read_out   = q_ctrl.mem_read   & q_valid;
    assign mem_write_out  = q_ctrl.mem_write  & q_valid;

    assign pcsrc     = q_ctrl.branch & zero_out & q_valid;
    // x0 is hardwired to zero, so a write to it is never forwarded.
    assign fwd_valid = q_valid & q_ctrl.reg_write & (rd_out != '0);

    // Count cycles where MEM holds off a valid entry; stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (q_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed bench for ex_mem_skid_reg: inputs change and outputs are
// sampled on the falling edge; the DUT updates on the rising edge.
module tb_ex_mem_skid_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] alu_data;
    logic [63:0] rs2_data;
    logic [31:0] pc_branch;
    logic        zero;
    logic [4:0]  rd;
    logic        mem_to_reg, reg_write, branch, mem_read, mem_write;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] alu_data_out;
    logic [63:0] rs2_data_out;
    logic [31:0] pc_branch_out;
    logic        zero_out;
    logic [4:0]  rd_out;
    logic        mem_to_reg_out, reg_write_out, branch_out, mem_read_out, mem_write_out;
    logic        pcsrc;
    logic        fwd_valid;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    // Clock: 10 ns period.
    always #5 clk = ~clk;

    ex_mem_skid_reg dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_data       (alu_data),
        .rs2_data       (rs2_data),
        .pc_branch      (pc_branch),
        .zero           (zero),
        .rd             (rd),
        .mem_to_reg     (mem_to_reg),
        .reg_write      (reg_write),
        .branch         (branch),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .alu_data_out   (alu_data_out),
        .rs2_data_out   (rs2_data_out),
        .pc_branch_out  (pc_branch_out),
        .zero_out       (zero_out),
        .rd_out         (rd_out),
        .mem_to_reg_out (mem_to_reg_out),
        .reg_write_out  (reg_write_out),
        .branch_out     (branch_out),
        .mem_read_out   (mem_read_out),
        .mem_write_out  (mem_write_out),
        .pcsrc          (pcsrc),
        .fwd_valid      (fwd_valid),
        .stall_cnt      (stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One rising edge, then return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [63:0] a, input logic [63:0] s, input logic [31:0] p,
                         input logic z, input logic [4:0] r, input logic m2r, input logic rw,
                         input logic br, input logic mr, input logic mw);
        in_valid   = 1'b1;
        alu_data   = a;
        rs2_data   = s;
        pc_branch  = p;
        zero       = z;
        rd         = r;
        mem_to_reg = m2r;
        reg_write  = rw;
        branch     = br;
        mem_read   = mr;
        mem_write  = mw;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_data = '0; rs2_data = '0; pc_branch = '0; zero = 1'b0; rd = '0;
        mem_to_reg = 1'b0; reg_write = 1'b0; branch = 1'b0; mem_read = 1'b0; mem_write = 1'b0;

        // Reset state
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_alu_out", alu_data_out, 0);
        check("rst_fwd_valid", fwd_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1. Pass-through
        out_ready = 1'b1;
        drive(100, 200, 300, 0, 10, 1, 1, 0, 1, 0);
        tick();
        check("t1_out_valid", out_valid, 1);
        check("t1_alu", alu_data_out, 100);
        check("t1_rs2", rs2_data_out, 200);
        check("t1_pc", pc_branch_out, 300);
        check("t1_rd", rd_out, 10);
        check("t1_m2r", mem_to_reg_out, 1);
        check("t1_rw", reg_write_out, 1);
        check("t1_mr", mem_read_out, 1);
        check("t1_mw", mem_write_out, 0);
        check("t1_fwd", fwd_valid, 1);
        check("t1_pcsrc", pcsrc, 0);
        check("t1_stall", stall_cnt, 0);
        in_valid = 1'b0;
        tick();
        check("t1_drain", out_valid, 0);

        // 2. Back-pressure with A then B
        out_ready = 1'b0;
        drive(150, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        tick();
        check("t2_a_valid", out_valid, 1);
        check("t2_a_alu", alu_data_out, 150);
        check("t2_a_ready", in_ready, 1);
        drive(160, 0, 0, 0, 2, 0, 1, 0, 0, 0);
        tick();
        check("t2_b_ready", in_ready, 0);
        check("t2_b_hold_alu", alu_data_out, 150);
        check("t2_b_stall", stall_cnt, 1);
        in_valid = 1'b0;
        tick();
        check("t2_hold_alu", alu_data_out, 150);
        check("t2_hold_rd", rd_out, 1);
        check("t2_hold_ready", in_ready, 0);
        check("t2_hold_stall", stall_cnt, 2);
        out_ready = 1'b1;
        #1;
        check("t2_a_shown", alu_data_out, 150);
        tick();
        check("t2_b_valid", out_valid, 1);
        check("t2_b_alu", alu_data_out, 160);
        check("t2_b_rd", rd_out, 2);
        check("t2_ready_back", in_ready, 1);
        tick();
        check("t2_empty", out_valid, 0);
        check("t2_stall_final", stall_cnt, 2);

        // 3. Branch taken
        drive(0, 0, 400, 1, 30, 0, 0, 1, 0, 0);
        tick();
        check("t3_pcsrc", pcsrc, 1);
        check("t3_pc", pc_branch_out, 400);
        check("t3_branch", branch_out, 1);
        check("t3_fwd", fwd_valid, 0);
        in_valid = 1'b0;
        tick();
        check("t3_pcsrc_off", pcsrc, 0);
        check("t3_empty", out_valid, 0);

        // 4. Flush with main and skid full, then flush against an accept
        out_ready = 1'b0;
        drive(500, 0, 0, 0, 3, 1, 1, 0, 1, 0);
        tick();
        drive(600, 0, 0, 0, 4, 1, 1, 0, 1, 1);
        tick();
        check("t4_full_ready", in_ready, 0);
        check("t4_full_alu", alu_data_out, 500);
        check("t4_pre_stall", stall_cnt, 3);
        drive(700, 0, 0, 1, 5, 1, 1, 1, 1, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("t4_valid", out_valid, 0);
        check("t4_ready", in_ready, 1);
        check("t4_m2r", mem_to_reg_out, 0);
        check("t4_rw", reg_write_out, 0);
        check("t4_mr", mem_read_out, 0);
        check("t4_mw", mem_write_out, 0);
        check("t4_fwd", fwd_valid, 0);
        check("t4_pcsrc", pcsrc, 0);
        check("t4_stall", stall_cnt, 4);
        out_ready = 1'b1;
        tick();
        check("t4_no_ghost", out_valid, 0);
        drive(800, 0, 0, 0, 6, 0, 1, 0, 0, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("t4_drop_accept", out_valid, 0);
        tick();
        check("t4_drop_after", out_valid, 0);

        // 5. x0 destination
        drive(900, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        check("t5_valid", out_valid, 1);
        check("t5_alu", alu_data_out, 900);
        check("t5_rw", reg_write_out, 1);
        check("t5_fwd", fwd_valid, 0);
        in_valid = 1'b0;
        tick();

        // 6. Async reset while both entries are held
        out_ready = 1'b0;
        drive(111, 0, 0, 0, 7, 0, 1, 0, 0, 0);
        tick();
        drive(222, 0, 0, 0, 8, 0, 1, 0, 0, 0);
        tick();
        in_valid = 1'b0;
        check("t6_full_ready", in_ready, 0);
        check("t6_stall", stall_cnt, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid", out_valid, 0);
        check("t6_ready", in_ready, 1);
        check("t6_stall_clr", stall_cnt, 0);
        check("t6_alu", alu_data_out, 0);
        check("t6_rw", reg_write_out, 0);
        check("t6_fwd", fwd_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("t6_after_valid", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
